dmem_responder: RTL

// - Memory-side responder for the pipeline MEM stage: accepts the CPU's load/store request and services it from a word array after LATENCY wait cycles.
// - Drives stall_o so the pipeline freezes its EX/MEM and earlier stages while an access is outstanding.
// - Lets the pipeline run against slow data memory instead of a zero-wait array.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } dmem_state_e;

    function automatic logic misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bundle between the CPU pipeline and the responder.
interface dmem_if;
    import dmem_pkg::*;

    logic [WORD_W-1:0] addr_i;
    logic [WORD_W-1:0] data_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic [WORD_W-1:0] data_o;
    logic              stall_o;
    logic              ack_o;
    logic              err_o;

    modport master (
        output addr_i, data_i, MemRead_i, MemWrite_i,
        input  data_o, stall_o, ack_o, err_o
    );

    modport slave (
        input  addr_i, data_i, MemRead_i, MemWrite_i,
        output data_o, stall_o, ack_o, err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, contents deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] idx_i,
    input  logic [WORD_W-1:0]    wdata_i,
    output logic [WORD_W-1:0]    rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_BITS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder with LATENCY wait cycles and pipeline stall.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no access outstanding; a request is captured on the next edge
//   WAIT   | counting down wait cycles; access performed when count hits 0
//   DONE   | one-cycle completion: ack_o high, stall_o low, load data valid
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 7,
    parameter int LATENCY   = 2
) (
    input  logic   clk_i,
    input  logic   rst_n,
    dmem_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  idx_q;
    logic [WORD_W-1:0]     wdata_q;
    logic                  wr_q;
    logic                  rd_valid_q;
    logic                  req;
    logic                  capture;
    logic                  access_edge;
    logic                  trap;
    logic                  arr_we;
    logic                  arr_re;
    logic [WORD_W-1:0]     arr_rdata;
    logic                  unused_addr_bits;

    assign req     = bus.MemRead_i | bus.MemWrite_i;
    assign capture = (state_q == S_IDLE) && req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (capture) begin
            mis_q <= misaligned(bus.addr_i[1:0]);
        end
    end

    assign trap = mis_q;
`else
    assign trap = 1'b0;
`endif

    // A simultaneous read+write request is serviced as a store.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (capture) begin
            idx_q   <= bus.addr_i[ADDR_BITS+1:2];
            wdata_q <= bus.data_i;
            wr_q    <= bus.MemWrite_i;
        end
    end

    assign access_edge = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign arr_we      = access_edge &&  wr_q && !trap;
    assign arr_re      = access_edge && !wr_q && !trap;

    // The array read register has no reset, so data_o is gated to 0 until a load lands.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else if (access_edge && !wr_q) begin
            rd_valid_q <= !trap;
        end
    end

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign bus.data_o  = rd_valid_q ? arr_rdata : '0;
    assign bus.stall_o = capture || (state_q == S_WAIT);
    assign bus.ack_o   = (state_q == S_DONE);
    assign bus.err_o   = (state_q == S_DONE) && trap;

    assign unused_addr_bits = ^{bus.addr_i[WORD_W-1:ADDR_BITS+2], bus.addr_i[1:0]};

endmodule
